// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller over a 16-line tag/data array.
// Define CACHE_STATS_EN to build the saturating hit/miss counters; otherwise they read as zero.
module cache_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        sram_we,
    output logic [15:0] sram_wl,
    output logic [3:0]  sram_tag_in,
    output logic [7:0]  sram_data_in,
    input  logic [3:0]  sram_tag_out,
    input  logic [7:0]  sram_data_out,
    output logic [7:0]  hit_cnt,
    output logic [7:0]  miss_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFetch,
        StWmem,
        StFill,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        hit_q;
    logic [7:0]  fill_q;
    logic [7:0]  rdata_q;
    logic [15:0] valid_q;

    logic [3:0]  idx;
    logic [3:0]  tag;
    logic        lookup_hit;

    assign idx        = addr_q[3:0];
    assign tag        = addr_q[7:4];
    assign lookup_hit = valid_q[idx] && (sram_tag_out == tag);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cpu_req) state_d = StLookup;
            StLookup: begin
                if (we_q)            state_d = StWmem;
                else if (lookup_hit) state_d = StDone;
                else                 state_d = StFetch;
            end
            StFetch:  if (mem_ack) state_d = StFill;
            StWmem:   if (mem_ack) state_d = hit_q ? StFill : StDone;
            StFill:   state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Transaction latches, fill data and valid vector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            hit_q   <= 1'b0;
            fill_q  <= 8'h00;
            rdata_q <= 8'h00;
            valid_q <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                    end
                end
                StLookup: begin
                    hit_q <= lookup_hit;
                    if (!we_q && lookup_hit) rdata_q <= sram_data_out;
                end
                StFetch: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        fill_q  <= mem_rdata;
                    end
                end
                StWmem: begin
                    // Write hit keeps the line coherent with memory.
                    if (mem_ack && hit_q) fill_q <= wdata_q;
                end
                StFill: valid_q[idx] <= 1'b1;
                default: ;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        cpu_ready    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 8'h00;
        mem_wdata    = 8'h00;
        sram_we      = 1'b0;
        sram_wl      = 16'h0000;
        sram_tag_in  = 4'h0;
        sram_data_in = 8'h00;
        unique case (state_q)
            StLookup: sram_wl = 16'h0001 << idx;
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            StWmem: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            StFill: begin
                sram_we      = 1'b1;
                sram_wl      = 16'h0001 << idx;
                sram_tag_in  = tag;
                sram_data_in = fill_q;
            end
            StDone:  cpu_ready = 1'b1;
            default: ;
        endcase
    end

    assign cpu_rdata = rdata_q;

`ifdef CACHE_STATS_EN
    logic [7:0] hit_cnt_q;
    logic [7:0] miss_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= 8'h00;
            miss_cnt_q <= 8'h00;
        end else if (state_q == StLookup) begin
            if (lookup_hit && hit_cnt_q != 8'hFF)   hit_cnt_q  <= hit_cnt_q + 8'h01;
            if (!lookup_hit && miss_cnt_q != 8'hFF) miss_cnt_q <= miss_cnt_q + 8'h01;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 8'h00;
    assign miss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: behavioural tag/data array and memory responder, table of
// accesses with hand-computed results, plus reset-abort, idle-ack and counter-saturation sequences.
module tb_cache_ctrl;

`ifdef CACHE_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr, cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        sram_we;
    logic [15:0] sram_wl;
    logic [3:0]  sram_tag_in, sram_tag_out;
    logic [7:0]  sram_data_in, sram_data_out;
    logic [7:0]  hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    cache_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ready    (cpu_ready),
        .cpu_rdata    (cpu_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .sram_we      (sram_we),
        .sram_wl      (sram_wl),
        .sram_tag_in  (sram_tag_in),
        .sram_data_in (sram_data_in),
        .sram_tag_out (sram_tag_out),
        .sram_data_out(sram_data_out),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    initial forever #5 clk = ~clk;

    // Behavioural array: combinational read of the selected row, write on the rising edge.
    logic [3:0] tag_arr [16];
    logic [7:0] dat_arr [16];
    logic [3:0] row;

    always_comb begin
        row = 4'h0;
        for (int i = 0; i < 16; i++) if (sram_wl[i]) row = 4'(i);
        sram_tag_out  = tag_arr[row];
        sram_data_out = dat_arr[row];
    end

    always @(posedge clk) begin
        if (sram_we) begin
            for (int i = 0; i < 16; i++) begin
                if (sram_wl[i]) begin
                    tag_arr[i] <= sram_tag_in;
                    dat_arr[i] <= sram_data_in;
                end
            end
        end
    end

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  md;        // memory read data returned with ack
        int          dly;       // ack asserted in this cycle of mem_req
        bit          exp_mem;
        logic [15:0] exp_wl;    // 0 means no fill expected
        logic [3:0]  exp_tag;
        logic [7:0]  exp_fdata;
        int          exp_lat;   // cycles from accepting edge to cpu_ready
        logic [7:0]  exp_rdata;
        int          exp_hit;   // counter values with statistics built
        int          exp_miss;
    } vec_t;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input vec_t v, output int lat, output logic [7:0] rd, output bit saw,
                          output logic mwe, output logic [7:0] maddr, output logic [7:0] mwd,
                          output int fills, output logic [15:0] wl, output logic [3:0] ftag,
                          output logic [7:0] fdata);
        int cyc;
        int waitc;
        bit done;
        lat = -1; rd = 8'h00; saw = 1'b0; mwe = 1'b0; maddr = 8'h00; mwd = 8'h00;
        fills = 0; wl = 16'h0000; ftag = 4'h0; fdata = 8'h00;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        cyc = 1; waitc = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            if (cpu_ready) begin
                lat = cyc; rd = cpu_rdata; done = 1'b1;
                mem_ack = 1'b0; mem_rdata = 8'h00;
            end else begin
                if (mem_req) begin
                    if (!saw) begin
                        saw = 1'b1; mwe = mem_we; maddr = mem_addr; mwd = mem_wdata;
                    end
                    waitc++;
                    mem_ack   = (waitc == v.dly);
                    mem_rdata = mem_ack ? v.md : 8'h00;
                end else begin
                    mem_ack = 1'b0; mem_rdata = 8'h00;
                end
                if (sram_we) begin
                    fills++; wl = sram_wl; ftag = sram_tag_in; fdata = sram_data_in;
                end
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int lat, fills;
        logic [7:0] rd, maddr, mwd, fdata;
        logic [15:0] wl;
        logic [3:0] ftag;
        logic mwe;
        bit saw;
        access(v, lat, rd, saw, mwe, maddr, mwd, fills, wl, ftag, fdata);
        check({nm, " latency"}, 80'(lat), 80'(v.exp_lat));
        check({nm, " mem_req seen"}, 80'(saw), 80'(v.exp_mem));
        if (v.exp_mem) begin
            check({nm, " mem_we"}, 80'(mwe), 80'(v.we));
            check({nm, " mem_addr"}, 80'(maddr), 80'(v.addr));
            if (v.we) check({nm, " mem_wdata"}, 80'(mwd), 80'(v.wdata));
        end
        check({nm, " fill cycles"}, 80'(fills), 80'((v.exp_wl != 16'h0) ? 1 : 0));
        if (v.exp_wl != 16'h0) begin
            check({nm, " fill wl"}, 80'(wl), 80'(v.exp_wl));
            check({nm, " fill tag"}, 80'(ftag), 80'(v.exp_tag));
            check({nm, " fill data"}, 80'(fdata), 80'(v.exp_fdata));
        end
        check({nm, " cpu_rdata"}, 80'(rd), 80'(v.exp_rdata));
        check({nm, " hit_cnt"}, 80'(hit_cnt), 80'(Stats ? v.exp_hit : 0));
        check({nm, " miss_cnt"}, 80'(miss_cnt), 80'(Stats ? v.exp_miss : 0));
    endtask

    vec_t vecs [9];

    initial begin
        vec_t v;
        int timeout;
        int bad;
        int lat, fills;
        logic [7:0] rd, maddr, mwd, fdata;
        logic [15:0] wl;
        logic [3:0] ftag;
        logic mwe;
        bit saw;

        //        we    addr   wdata  md     dly mem wl        tag   fdata  lat rdata  hit miss
        vecs[0] = '{1'b0, 8'h35, 8'h00, 8'hA7, 3, 1, 16'h0020, 4'h3, 8'hA7, 6, 8'hA7, 0, 1};
        vecs[1] = '{1'b0, 8'h35, 8'h00, 8'h00, 3, 0, 16'h0000, 4'h0, 8'h00, 2, 8'hA7, 1, 1};
        vecs[2] = '{1'b0, 8'h45, 8'h00, 8'h3C, 3, 1, 16'h0020, 4'h4, 8'h3C, 6, 8'h3C, 1, 2};
        vecs[3] = '{1'b0, 8'h35, 8'h00, 8'hA7, 3, 1, 16'h0020, 4'h3, 8'hA7, 6, 8'hA7, 1, 3};
        vecs[4] = '{1'b0, 8'h45, 8'h00, 8'h3C, 1, 1, 16'h0020, 4'h4, 8'h3C, 4, 8'h3C, 1, 4};
        vecs[5] = '{1'b1, 8'h45, 8'h5C, 8'h00, 3, 1, 16'h0020, 4'h4, 8'h5C, 6, 8'h3C, 2, 4};
        vecs[6] = '{1'b0, 8'h45, 8'h00, 8'h00, 3, 0, 16'h0000, 4'h0, 8'h00, 2, 8'h5C, 3, 4};
        vecs[7] = '{1'b1, 8'h1F, 8'h11, 8'h00, 2, 1, 16'h0000, 4'h0, 8'h00, 4, 8'h5C, 3, 5};
        vecs[8] = '{1'b0, 8'h1F, 8'h00, 8'h22, 1, 1, 16'h8000, 4'h1, 8'h22, 4, 8'h22, 3, 6};

        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #3;
        check("reset outputs", {cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
                                sram_we, sram_wl, sram_tag_in, sram_data_in, hit_cnt, miss_cnt},
              80'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Abort a read miss in FETCH with an asynchronous reset.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h35;
        @(negedge clk);
        cpu_req = 1'b0; cpu_addr = 8'h00;
        timeout = 0;
        while (!mem_req && timeout < 10) begin
            @(negedge clk);
            timeout++;
        end
        check("abort reached fetch", 80'(mem_req), 80'h1);
        #2 reset_n = 1'b0;
        #1;
        check("abort mem_req", 80'(mem_req), 80'h0);
        check("abort outputs", {cpu_ready, cpu_rdata, sram_we, sram_wl, hit_cnt, miss_cnt}, 80'h0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (sram_we || mem_req || cpu_ready) bad++;
        end
        check("abort quiet in reset", 80'(bad), 80'h0);
        reset_n = 1'b1;
        v = '{1'b0, 8'h35, 8'h00, 8'hA7, 3, 1, 16'h0020, 4'h3, 8'hA7, 6, 8'hA7, 0, 1};
        run_vec("post-reset read", v);

        // Acks outside FETCH/WMEM must be ignored.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        repeat (2) @(negedge clk);
        check("idle ack mem_req", 80'(mem_req), 80'h0);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        v = '{1'b0, 8'h35, 8'h00, 8'h00, 3, 0, 16'h0000, 4'h0, 8'h00, 2, 8'hA7, 1, 1};
        run_vec("hit after idle ack", v);

        // 299 more hits: 300 in total, hit counter saturates.
        bad = 0;
        v = '{1'b0, 8'h35, 8'h00, 8'h00, 3, 0, 16'h0000, 4'h0, 8'h00, 2, 8'hA7, 0, 0};
        for (int i = 0; i < 299; i++) begin
            access(v, lat, rd, saw, mwe, maddr, mwd, fills, wl, ftag, fdata);
            if (lat != 2 || saw || fills != 0 || rd != 8'hA7) bad++;
        end
        check("repeated hits clean", 80'(bad), 80'h0);
        check("hit_cnt saturated", 80'(hit_cnt), 80'(Stats ? 8'hFF : 8'h00));
        check("miss_cnt after hits", 80'(miss_cnt), 80'(Stats ? 8'h01 : 8'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock, rising edge); reset_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL have CPU ports: cpu_req in 1 (request); cpu_we in 1 (1=write); cpu_addr in 8 ([7:4] tag, [3:0] index); cpu_wdata in 8; cpu_ready out 1 (done strobe); cpu_rdata out 8.
REQ-003 SHALL have memory ports: mem_req out 1; mem_we out 1; mem_addr out 8; mem_wdata out 8; mem_ack in 1; mem_rdata in 8.
REQ-004 SHALL have array ports: sram_we out 1; sram_wl out 16 (one-hot wordline); sram_tag_in out 4; sram_data_in out 8; sram_tag_out in 4; sram_data_out in 8 (combinational read of the selected row).
REQ-005 SHALL have statistics ports: hit_cnt out 8; miss_cnt out 8.

Function
REQ-006 SHALL implement a 16-line direct-mapped, write-through, no-write-allocate cache over the 16x(4-bit tag, 8-bit data) array, with a 16-bit valid vector held internally.
REQ-007 FSM states SHALL be IDLE, LOOKUP, FETCH, WMEM, FILL, DONE.
REQ-008 IDLE: on cpu_req=1 at a rising edge, latch cpu_we/cpu_addr/cpu_wdata and go to LOOKUP; cpu_req SHALL be ignored in every other state.
REQ-009 LOOKUP: sram_wl=1<<index, sram_we=0; hit = valid[index] && sram_tag_out==tag; hit is registered.
REQ-010 LOOKUP next state: read hit -> DONE with cpu_rdata<=sram_data_out; read miss -> FETCH; any write -> WMEM.
REQ-011 FETCH: mem_req=1, mem_we=0, mem_addr=latched addr; hold until mem_ack=1; on ack capture mem_rdata into cpu_rdata and the fill register, go to FILL.
REQ-012 WMEM: mem_req=1, mem_we=1, mem_addr=latched addr, mem_wdata=latched wdata; on ack: registered hit -> FILL with fill data=latched wdata; miss -> DONE.
REQ-013 FILL: exactly one cycle with sram_we=1, sram_wl=1<<index, sram_tag_in=tag, sram_data_in=fill data; set valid[index]; go to DONE.
REQ-014 DONE: cpu_ready=1 for exactly one cycle; go to IDLE; cpu_ready=0 in all other states.
REQ-015 Read-hit latency SHALL be 2 cycles: cpu_ready high in the second cycle after the accepting edge.
REQ-016 In IDLE/DONE sram_wl SHALL be 16'h0000 and sram_we=0; mem_req SHALL be 0 outside FETCH/WMEM; mem_ack outside FETCH/WMEM SHALL be ignored.
REQ-017 Outputs SHALL be Moore-decoded from state and latched registers (no combinational cpu_* to mem_*/sram_* path).

Reset
REQ-018 reset_n=0 SHALL asynchronously force IDLE, valid=0, cpu_rdata=0, hit_cnt=0, miss_cnt=0; all outputs 0 while in reset.
REQ-019 Reset mid-operation (any state) SHALL abandon the transaction: mem_req and sram_we drop immediately; no FILL occurs.

Configuration
REQ-020 Macro CACHE_STATS_EN defined: hit_cnt/miss_cnt increment by 1 in each LOOKUP cycle on hit/miss respectively (reads and writes), saturating at 8'hFF.
REQ-021 CACHE_STATS_EN undefined: counters not built; hit_cnt and miss_cnt tied to 8'h00; all other behaviour identical.

Verification
REQ-022 After reset, read 0x35: mem_req with mem_addr=0x35; mem_ack+mem_rdata=0xA7 after 3 cycles -> FILL sram_wl=16'h0020, tag 3, data 0xA7 -> cpu_ready with cpu_rdata=0xA7; miss_cnt=1.
REQ-023 Read 0x35 again: no mem_req, cpu_ready 2 cycles after accept, cpu_rdata=0xA7, hit_cnt=1.
REQ-024 Read 0x45 (same index, tag 4): miss, fetch 0x3C, line 5 tag becomes 4; following read 0x35 misses.
REQ-025 Write 0x45 data 0x5C: mem write 0x45/0x5C, then FILL updates line 5; read 0x45 hits returning 0x5C. Write 0x1F data 0x11 (miss): mem write only, no sram_we; read 0x1F then misses.
REQ-026 Drop reset_n during FETCH: mem_req=0 immediately, no sram_we; after release read 0x35 misses.
REQ-027 With CACHE_STATS_EN, 300 consecutive hits -> hit_cnt=8'hFF; without it hit_cnt=miss_cnt=0 throughout.
